// File: rtl/motor_mix_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | motor_mix_pkg                                                         |
// | Shared state encoding and default parameters for the motor mixer.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package motor_mix_pkg;

    localparam int DEF_DUTY_WIDTH = 17;
    localparam int DEF_MAX_OFFSET = 18500;
    localparam int DEF_SLEW_STEP  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_e;

endpackage : motor_mix_pkg
`default_nettype wire

// File: rtl/slew_limiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | slew_limiter                                                          |
// | Moves one duty value toward its target by at most SLEW_STEP per tick. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module slew_limiter
    import motor_mix_pkg::*;
#(
    parameter int DUTY_WIDTH = DEF_DUTY_WIDTH,
    parameter int SLEW_STEP  = DEF_SLEW_STEP
) (
    input  logic [DUTY_WIDTH-1:0] target_i,
    input  logic [DUTY_WIDTH-1:0] duty_i,
    input  logic                  tick_i,
    output logic [DUTY_WIDTH-1:0] duty_next_o,
    output logic                  at_target_o
);

    localparam logic [DUTY_WIDTH-1:0] C_STEP = DUTY_WIDTH'(SLEW_STEP);

    logic                  w_up;
    logic [DUTY_WIDTH-1:0] w_delta;

    always_comb begin
        w_up        = (target_i > duty_i);
        w_delta     = w_up ? (target_i - duty_i) : (duty_i - target_i);
        duty_next_o = duty_i;
        if (tick_i) begin
            // A zero step disables limiting entirely.
            if ((SLEW_STEP == 0) || (w_delta <= C_STEP)) begin
                duty_next_o = target_i;
            end else if (w_up) begin
                duty_next_o = duty_i + C_STEP;
            end else begin
                duty_next_o = duty_i - C_STEP;
            end
        end
    end

    assign at_target_o = (duty_next_o == target_i);

endmodule : slew_limiter
`default_nettype wire

// File: rtl/motor_mix_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | motor_mix_ctrl                                                        |
// | Differential motor mixer with clamped offset, soft start/stop FSM.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module motor_mix_ctrl
    import motor_mix_pkg::*;
#(
    parameter int DUTY_WIDTH = DEF_DUTY_WIDTH,
    parameter int MAX_OFFSET = DEF_MAX_OFFSET,
    parameter int SLEW_STEP  = DEF_SLEW_STEP
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic                         toggle_req,
    input  logic        [DUTY_WIDTH-1:0] base_duty,
    input  logic signed [DUTY_WIDTH:0]   offset_in,
    output logic        [DUTY_WIDTH-1:0] duty_l,
    output logic        [DUTY_WIDTH-1:0] duty_r,
    output logic                         motor_en,
    output logic        [1:0]            state_o,
    output logic                         offset_sat
);

    localparam int AW = DUTY_WIDTH + 3;
    localparam logic signed [AW-1:0] C_MAX_OFF  = AW'(MAX_OFFSET);
    localparam logic signed [AW-1:0] C_MIN_OFF  = -C_MAX_OFF;
    localparam logic signed [AW-1:0] C_DUTY_MAX = $signed({3'b000, {DUTY_WIDTH{1'b1}}});

    state_e                  state_q, state_d;
    logic [DUTY_WIDTH-1:0]   duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic                    motor_en_q, motor_en_d;
    logic                    sat_q, sat_d;
    logic                    tog_q;

    logic signed [AW-1:0]    w_off_ext, w_off_c, w_base_ext, w_sum_r, w_sum_l;
    logic                    w_clamped, w_tog_edge;
    logic [DUTY_WIDTH-1:0]   w_tgt_r, w_tgt_l, w_st_tgt_r, w_st_tgt_l;
    logic [DUTY_WIDTH-1:0]   w_next_l, w_next_r;
    logic                    w_at_l, w_at_r;

    assign w_tog_edge = toggle_req & ~tog_q;
    assign w_off_ext  = {{2{offset_in[DUTY_WIDTH]}}, offset_in};
    assign w_base_ext = {3'b000, base_duty};

    always_comb begin
        w_off_c   = w_off_ext;
        w_clamped = 1'b0;
        if (w_off_ext > C_MAX_OFF) begin
            w_off_c   = C_MAX_OFF;
            w_clamped = 1'b1;
        end else if (w_off_ext < C_MIN_OFF) begin
            w_off_c   = C_MIN_OFF;
            w_clamped = 1'b1;
        end
        w_sum_r = w_base_ext + w_off_c;
        w_sum_l = w_base_ext - w_off_c;

        if (w_sum_r < 0)               w_tgt_r = '0;
        else if (w_sum_r > C_DUTY_MAX) w_tgt_r = {DUTY_WIDTH{1'b1}};
        else                           w_tgt_r = w_sum_r[DUTY_WIDTH-1:0];

        if (w_sum_l < 0)               w_tgt_l = '0;
        else if (w_sum_l > C_DUTY_MAX) w_tgt_l = {DUTY_WIDTH{1'b1}};
        else                           w_tgt_l = w_sum_l[DUTY_WIDTH-1:0];
    end

    // Only RAMP and RUN drive toward the mix; IDLE and STOP aim at zero.
    assign w_st_tgt_l = ((state_q == ST_RAMP) || (state_q == ST_RUN)) ? w_tgt_l : '0;
    assign w_st_tgt_r = ((state_q == ST_RAMP) || (state_q == ST_RUN)) ? w_tgt_r : '0;

    slew_limiter #(
        .DUTY_WIDTH (DUTY_WIDTH),
        .SLEW_STEP  (SLEW_STEP)
    ) u_slew_l (
        .target_i    (w_st_tgt_l),
        .duty_i      (duty_l_q),
        .tick_i      (clk_en),
        .duty_next_o (w_next_l),
        .at_target_o (w_at_l)
    );

    slew_limiter #(
        .DUTY_WIDTH (DUTY_WIDTH),
        .SLEW_STEP  (SLEW_STEP)
    ) u_slew_r (
        .target_i    (w_st_tgt_r),
        .duty_i      (duty_r_q),
        .tick_i      (clk_en),
        .duty_next_o (w_next_r),
        .at_target_o (w_at_r)
    );

    always_comb begin
        state_d  = state_q;
        duty_l_d = w_next_l;
        duty_r_d = w_next_r;
        sat_d    = clk_en ? w_clamped : sat_q;
        if (state_q == ST_IDLE) begin
            duty_l_d = '0;
            duty_r_d = '0;
        end

        // A toggle edge outranks any tick-driven transition in the same cycle.
        if (w_tog_edge) begin
            case (state_q)
                ST_IDLE: state_d = ST_RAMP;
                ST_RAMP: state_d = ST_STOP;
                ST_RUN:  state_d = ST_STOP;
                ST_STOP: state_d = ST_RAMP;
                default: state_d = ST_IDLE;
            endcase
        end else if (clk_en) begin
            if ((state_q == ST_RAMP) && w_at_l && w_at_r) begin
                state_d = ST_RUN;
            end else if ((state_q == ST_STOP) && w_at_l && w_at_r) begin
                state_d = ST_IDLE;
            end
        end

        motor_en_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            duty_l_q   <= '0;
            duty_r_q   <= '0;
            motor_en_q <= 1'b0;
            sat_q      <= 1'b0;
            tog_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_l_q   <= duty_l_d;
            duty_r_q   <= duty_r_d;
            motor_en_q <= motor_en_d;
            sat_q      <= sat_d;
            tog_q      <= toggle_req;
        end
    end

    assign duty_l     = duty_l_q;
    assign duty_r     = duty_r_q;
    assign motor_en   = motor_en_q;
    assign state_o    = state_q;
    assign offset_sat = sat_q;

endmodule : motor_mix_ctrl
`default_nettype wire

// File: tb/tb_motor_mix_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_motor_mix_ctrl                                                     |
// | Scoreboard bench for motor_mix_ctrl plus a no-slew saturation DUT.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_motor_mix_ctrl;

    localparam int DW   = 17;
    localparam int MO   = 18500;
    localparam int STEP = 4096;
    localparam int MAXD = 131071;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_en = 1'b0;
    logic          toggle_req = 1'b0;
    logic [DW-1:0] base_duty = '0;
    logic [DW:0]   offset_in = '0;
    logic [DW-1:0] duty_l, duty_r;
    logic          motor_en, offset_sat;
    logic [1:0]    state_o;

    logic          clk_en2 = 1'b0;
    logic          toggle_req2 = 1'b0;
    logic [DW-1:0] base_duty2 = '0;
    logic [DW:0]   offset_in2 = '0;
    logic [DW-1:0] duty_l2, duty_r2;
    logic          motor_en2, offset_sat2;
    logic [1:0]    state_o2;

    always #5 clk = ~clk;

    motor_mix_ctrl #(.DUTY_WIDTH(DW), .MAX_OFFSET(MO), .SLEW_STEP(STEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .toggle_req (toggle_req),
        .base_duty  (base_duty),
        .offset_in  (offset_in),
        .duty_l     (duty_l),
        .duty_r     (duty_r),
        .motor_en   (motor_en),
        .state_o    (state_o),
        .offset_sat (offset_sat)
    );

    motor_mix_ctrl #(.DUTY_WIDTH(DW), .MAX_OFFSET(MO), .SLEW_STEP(0)) dut_noslew (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en2),
        .toggle_req (toggle_req2),
        .base_duty  (base_duty2),
        .offset_in  (offset_in2),
        .duty_l     (duty_l2),
        .duty_r     (duty_r2),
        .motor_en   (motor_en2),
        .state_o    (state_o2),
        .offset_sat (offset_sat2)
    );

    typedef struct {
        int dl;
        int dr;
        int en;
        int st;
        int sat;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int   m_st = 0, m_dl = 0, m_dr = 0, m_en = 0, m_sat = 0;
    bit   m_tprev = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic int lim(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int slew(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d <= STEP && d >= -STEP) return tgt;
        return (d > 0) ? cur + STEP : cur - STEP;
    endfunction

    // Reference behaviour, advanced once per clock and queued for comparison.
    task automatic model(input bit rst_v, input bit tog_v, input bit en_v,
                         input int base_v, input int off_v);
        int offc, tl, tr, gl, gr, nl, nr, ns;
        bit run;
        if (rst_v) begin
            m_st = 0; m_dl = 0; m_dr = 0; m_en = 0; m_sat = 0; m_tprev = 0;
            return;
        end
        offc = lim(off_v, -MO, MO);
        tr   = lim(base_v + offc, 0, MAXD);
        tl   = lim(base_v - offc, 0, MAXD);
        run  = (m_st == 1) || (m_st == 2);
        gl   = run ? tl : 0;
        gr   = run ? tr : 0;
        nl   = m_dl;
        nr   = m_dr;
        if (en_v) begin
            nl    = slew(m_dl, gl);
            nr    = slew(m_dr, gr);
            m_sat = (off_v > MO || off_v < -MO) ? 1 : 0;
        end
        if (m_st == 0) begin
            nl = 0;
            nr = 0;
        end
        ns = m_st;
        if (tog_v && !m_tprev) begin
            ns = (m_st == 0) ? 1 : (m_st == 3) ? 1 : 3;
        end else if (en_v) begin
            if (m_st == 1 && nl == gl && nr == gr) ns = 2;
            if (m_st == 3 && nl == 0 && nr == 0)   ns = 0;
        end
        m_st = ns; m_dl = nl; m_dr = nr;
        m_en = (ns != 0) ? 1 : 0;
        m_tprev = tog_v;
    endtask

    task automatic step(input bit rst_v, input bit tog_v, input bit en_v,
                        input int base_v, input int off_v);
        exp_t e;
        reset      = rst_v;
        toggle_req = tog_v;
        clk_en     = en_v;
        base_duty  = DW'(base_v);
        offset_in  = (DW+1)'(off_v);
        model(rst_v, tog_v, en_v, base_v, off_v);
        e.dl = m_dl; e.dr = m_dr; e.en = m_en; e.st = m_st; e.sat = m_sat;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        chk("sb_duty_l",   int'(duty_l),     e.dl);
        chk("sb_duty_r",   int'(duty_r),     e.dr);
        chk("sb_motor_en", int'(motor_en),   e.en);
        chk("sb_state",    int'(state_o),    e.st);
        chk("sb_sat",      int'(offset_sat), e.sat);
    endtask

    task automatic tick(input int base_v, input int off_v);
        step(0, 0, 1, base_v, off_v);
        step(0, 0, 0, base_v, off_v);
    endtask

    initial begin
        // Reset held with toggle and tick active.
        step(1, 1, 1, 24600, 0);
        step(1, 1, 1, 24600, 0);
        chk("rst_duty_l", int'(duty_l), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_motor_en", int'(motor_en), 0);
        step(0, 0, 0, 24600, 0);

        // Soft start.
        step(0, 1, 0, 24600, 0);
        chk("soft_state", int'(state_o), 1);
        chk("soft_motor_en", int'(motor_en), 1);
        step(0, 0, 0, 24600, 0);
        for (int k = 1; k <= 7; k++) begin
            step(0, 0, 1, 24600, 0);
            chk("soft_duty_r", int'(duty_r), (k < 7) ? 4096 * k : 24600);
            chk("soft_duty_l", int'(duty_l), (k < 7) ? 4096 * k : 24600);
            step(0, 0, 0, 24600, 0);
        end
        chk("soft_run", int'(state_o), 2);

        // Positive clamp.
        step(0, 0, 1, 24600, 30000);
        chk("clamp_sat", int'(offset_sat), 1);
        chk("clamp_r1", int'(duty_r), 28696);
        chk("clamp_l1", int'(duty_l), 20504);
        step(0, 0, 0, 24600, 30000);
        for (int k = 0; k < 4; k++) tick(24600, 30000);
        chk("clamp_r_final", int'(duty_r), 43100);
        chk("clamp_l_final", int'(duty_l), 6100);

        // Negative clamp mirrors.
        for (int k = 0; k < 10; k++) tick(24600, -30000);
        chk("nclamp_sat", int'(offset_sat), 1);
        chk("nclamp_r", int'(duty_r), 6100);
        chk("nclamp_l", int'(duty_l), 43100);
        for (int k = 0; k < 5; k++) tick(24600, 0);
        chk("center_sat", int'(offset_sat), 0);
        chk("center_r", int'(duty_r), 24600);
        chk("center_state", int'(state_o), 2);

        // Stop from RUN.
        step(0, 1, 0, 24600, 0);
        chk("stop_state", int'(state_o), 3);
        step(0, 0, 0, 24600, 0);
        for (int k = 1; k <= 7; k++) begin
            step(0, 0, 1, 24600, 0);
            chk("stop_duty_l", int'(duty_l), (24600 - 4096 * k > 0) ? 24600 - 4096 * k : 0);
            chk("stop_state_k", int'(state_o), (k < 7) ? 3 : 0);
            step(0, 0, 0, 24600, 0);
        end
        chk("stop_motor_en", int'(motor_en), 0);

        // Simultaneous toggle and tick during RAMP at 8192.
        step(0, 1, 0, 24600, 0);
        step(0, 0, 0, 24600, 0);
        tick(24600, 0);
        tick(24600, 0);
        chk("sim_pre", int'(duty_r), 8192);
        step(0, 1, 1, 24600, 0);
        chk("sim_duty_r", int'(duty_r), 12288);
        chk("sim_duty_l", int'(duty_l), 12288);
        chk("sim_state", int'(state_o), 3);
        step(0, 0, 0, 24600, 0);

        // Long toggle pulse counts once: STOP -> RAMP only.
        step(0, 1, 0, 24600, 0);
        step(0, 1, 0, 24600, 0);
        step(0, 1, 0, 24600, 0);
        chk("long_tog_state", int'(state_o), 1);
        step(0, 0, 0, 24600, 0);
        tick(24600, 0);
        chk("ramp_resume", int'(duty_r), 16384);

        // Reset mid-RAMP aborts at once.
        step(1, 0, 1, 24600, 0);
        chk("abort_duty_r", int'(duty_r), 0);
        chk("abort_state", int'(state_o), 0);
        chk("abort_motor_en", int'(motor_en), 0);
        step(0, 0, 0, 24600, 0);

        // Saturation with slew disabled.
        base_duty2  = DW'(120000);
        offset_in2  = (DW+1)'(18500);
        toggle_req2 = 1'b1;
        @(posedge clk); #1;
        toggle_req2 = 1'b0;
        clk_en2     = 1'b1;
        @(posedge clk); #1;
        clk_en2     = 1'b0;
        chk("nos_duty_r", int'(duty_r2), 131071);
        chk("nos_duty_l", int'(duty_l2), 101500);
        chk("nos_sat_edge", int'(offset_sat2), 0);
        chk("nos_state", int'(state_o2), 2);
        offset_in2 = (DW+1)'(30000);
        clk_en2    = 1'b1;
        @(posedge clk); #1;
        clk_en2    = 1'b0;
        chk("nos_sat", int'(offset_sat2), 1);
        chk("nos_duty_r2", int'(duty_r2), 131071);
        chk("nos_motor_en", int'(motor_en2), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_motor_mix_ctrl
`default_nettype wire

// File: doc/motor_mix_ctrl.md
MOTOR_MIX_CTRL -- requirements
Module: motor_mix_ctrl

Interface
REQ-001 SHALL have parameter DUTY_WIDTH, default 17: PWM duty word width; max duty 2^DUTY_WIDTH-1.
REQ-002 SHALL have parameter MAX_OFFSET, default 18500: symmetric clamp magnitude applied to offset_in.
REQ-003 SHALL have parameter SLEW_STEP, default 4096: max duty change per update tick; 0 means no slew limit.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port clk_en, input, 1: update-tick strobe, one cycle wide.
REQ-007 SHALL have port toggle_req, input, 1: single-cycle run/stop request from the debounced bumper.
REQ-008 SHALL have port base_duty, input, DUTY_WIDTH: unsigned base duty.
REQ-009 SHALL have port offset_in, input, DUTY_WIDTH+1: signed PID control output.
REQ-010 SHALL have port duty_l, output, DUTY_WIDTH: left PWM duty.
REQ-011 SHALL have port duty_r, output, DUTY_WIDTH: right PWM duty.
REQ-012 SHALL have port motor_en, output, 1: motor driver enable.
REQ-013 SHALL have port state_o, output, 2: current FSM state encoding.
REQ-014 SHALL have port offset_sat, output, 1: registered flag, high when the last tick clamped offset_in.

Function
REQ-015 SHALL compute off_c = offset_in clamped to [-MAX_OFFSET, +MAX_OFFSET].
REQ-016 SHALL compute run targets tgt_r = base_duty + off_c and tgt_l = base_duty - off_c.
REQ-017 SHALL saturate each target to [0, 2^DUTY_WIDTH-1], using at least DUTY_WIDTH+2 bits for intermediate arithmetic.
REQ-018 SHALL implement an FSM with states IDLE=0, RAMP=1, RUN=2, STOP=3.
REQ-019 SHALL use per-state targets: IDLE targets 0 with duties forced to 0; RAMP and RUN use tgt_l/tgt_r; STOP targets 0.
REQ-020 SHALL update duty registers only on cycles with clk_en=1, with the new value visible the following cycle.
REQ-021 SHALL, on an update, set duty = tgt if |tgt-duty| <= SLEW_STEP, otherwise move duty SLEW_STEP toward tgt; with SLEW_STEP=0, duty = tgt.
REQ-022 SHALL transition IDLE -> RAMP on toggle_req.
REQ-023 SHALL transition RAMP -> RUN on a tick where both updated duties equal their targets.
REQ-024 SHALL transition RAMP or RUN -> STOP on toggle_req.
REQ-025 SHALL transition STOP -> RAMP on toggle_req.
REQ-026 SHALL transition STOP -> IDLE on a tick where both updated duties equal 0.
REQ-027 SHALL drive motor_en=1 in RAMP, RUN and STOP, and motor_en=0 in IDLE, registered from the state.
REQ-028 SHALL give toggle_req priority over tick-based transitions when both occur in the same cycle.
REQ-029 SHALL compute a duty update in that same-cycle case using the pre-transition state's target.
REQ-030 SHALL keep RUN slew-limited, so a target step produces a ramp.
REQ-031 SHALL update offset_sat only on ticks.
REQ-032 SHALL ignore toggle_req pulses longer than one cycle beyond their first cycle, detecting on the rising edge.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set state IDLE, duty_l=0, duty_r=0, motor_en=0, offset_sat=0 and clear the toggle edge detector.
REQ-034 SHALL let reset mid-RAMP, RUN or STOP abort immediately with no ramp-down, and SHALL give reset priority over clk_en and toggle_req.

Structure
REQ-035 SHALL take the state enum type, state encodings and default parameter values from a shared package, motor_mix_pkg.
REQ-036 SHALL instantiate one sub-module per side, slew_limiter (inputs target, current duty, tick; outputs next duty and at_target).
REQ-037 SHALL keep clamp and target arithmetic combinational in motor_mix_ctrl, with all outputs registered.

Verification
REQ-038 SHALL verify reset: assert reset for 2 cycles with toggle_req=1 and clk_en=1 -> duties 0, motor_en 0, state_o 0.
REQ-039 SHALL verify soft start: base 24600, offset 0, one toggle pulse, then ticks -> duties 4096, 8192, ..., 24576, then 24600 on tick 7; state_o goes 1 then 2; motor_en=1 from the cycle after the toggle.
REQ-040 SHALL verify clamp: in RUN at 24600, offset_in=+30000 -> offset_sat=1; duty_r targets 43100 (+4096 per tick), duty_l targets 6100; offset_in=-30000 mirrors this.
REQ-041 SHALL verify saturation: SLEW_STEP=0, base 120000, offset +18500 -> duty_r=131071, duty_l=101500 on the first tick.
REQ-042 SHALL verify stop: toggle in RUN at 24600/24600 -> state 3; duties step down 4096 per tick to 0; then state 0 and motor_en 0 the cycle after.
REQ-043 SHALL verify simultaneous events: toggle_req and clk_en in the same cycle during RAMP at 8192 -> duties 12288 and state STOP; reset asserted mid-RAMP -> all zero the next cycle.
